// File: rtl/uart_frame_tx.sv
// UART frame transmitter: buffers words in a small FIFO and serialises each one
// as start + data (LSB first) + optional parity + stop bit(s).
module uart_frame_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE   = 16,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic [DATA_WIDTH-1:0]               IN_DATA,
  input  logic                                IN_VALID,
  output logic                                IN_READY,
  input  logic                                PAR_EN,
  input  logic                                PAR_TYP,
  output logic                                TX_OUT,
  output logic                                BUSY,
  output logic                                FRAME_DONE,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     FIFO_COUNT
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned PsW  = $clog2(PRESCALE);
  localparam int unsigned BitW = $clog2(DATA_WIDTH);

  localparam logic [PsW-1:0]  PsLast   = PsW'(PRESCALE - 1);
  localparam logic [BitW-1:0] DataLast = BitW'(DATA_WIDTH - 1);
  localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);
  localparam logic [CntW-1:0] CntFull  = CntW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic                  push, pop;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] head;

  assign IN_READY   = (count_q != CntFull);
  assign push       = IN_VALID & IN_READY;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign FIFO_COUNT = count_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Storage needs no reset: only entries counted by count_q are ever read.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= IN_DATA;
  end

  // ---------------------------------------------------------------------------
  // Frame serialiser
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [PsW-1:0]        cnt_q, cnt_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  cnt_last;
  logic                  load;
  logic                  tx;
  logic                  frame_done;

  assign cnt_last = (cnt_q == PsLast);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    load       = 1'b0;
    pop        = 1'b0;
    tx         = 1'b1;
    frame_done = 1'b0;

    if (state_q != StIdle) begin
      cnt_d = cnt_last ? '0 : cnt_q + PsW'(1);
    end

    unique case (state_q)
      StIdle: begin
        tx   = 1'b1;
        load = !fifo_empty;
      end
      StStart: begin
        tx = 1'b0;
        if (cnt_last) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        tx = shift_q[0];
        if (cnt_last) begin
          shift_d = shift_q >> 1;
          if (bit_q == DataLast) begin
            bit_d   = '0;
            state_d = par_en_q ? StParity : StStop;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      StParity: begin
        tx = par_bit_q;
        if (cnt_last) begin
          state_d = StStop;
          bit_d   = '0;
        end
      end
      StStop: begin
        tx = 1'b1;
        if (cnt_last) begin
          if (bit_q == StopLast) begin
            frame_done = 1'b1;
            bit_d      = '0;
            state_d    = StIdle;
            // A queued word starts its frame straight after the stop bit.
            load       = !fifo_empty;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Parity settings are captured with the word so later changes wait for the next frame.
    if (load) begin
      pop       = 1'b1;
      state_d   = StStart;
      cnt_d     = '0;
      bit_d     = '0;
      shift_d   = head;
      par_en_d  = PAR_EN;
      par_bit_d = (^head) ^ PAR_TYP;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end

  assign TX_OUT     = tx;
  assign BUSY       = (state_q != StIdle);
  assign FRAME_DONE = frame_done;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx: expected line waveforms come from a
// bit-list model of the frame format, compared cycle by cycle.
module tb_uart_frame_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  // dut0: defaults
  logic [7:0] d0_data;
  logic       d0_valid, d0_ready, d0_pe, d0_pt, d0_tx, d0_busy, d0_done;
  logic [2:0] d0_cnt;
  // dut1: two stop bits
  logic [7:0] d1_data;
  logic       d1_valid, d1_ready, d1_pe, d1_pt, d1_tx, d1_busy, d1_done;
  logic [2:0] d1_cnt;
  // dut2: 7 data bits, prescale 4
  logic [6:0] d2_data;
  logic       d2_valid, d2_ready, d2_pe, d2_pt, d2_tx, d2_busy, d2_done;
  logic [2:0] d2_cnt;

  uart_frame_tx dut0 (
    .CLK(clk), .RST(rst), .IN_DATA(d0_data), .IN_VALID(d0_valid), .IN_READY(d0_ready),
    .PAR_EN(d0_pe), .PAR_TYP(d0_pt), .TX_OUT(d0_tx), .BUSY(d0_busy),
    .FRAME_DONE(d0_done), .FIFO_COUNT(d0_cnt)
  );

  uart_frame_tx #(.STOP_BITS(2)) dut1 (
    .CLK(clk), .RST(rst), .IN_DATA(d1_data), .IN_VALID(d1_valid), .IN_READY(d1_ready),
    .PAR_EN(d1_pe), .PAR_TYP(d1_pt), .TX_OUT(d1_tx), .BUSY(d1_busy),
    .FRAME_DONE(d1_done), .FIFO_COUNT(d1_cnt)
  );

  uart_frame_tx #(.DATA_WIDTH(7), .PRESCALE(4)) dut2 (
    .CLK(clk), .RST(rst), .IN_DATA(d2_data), .IN_VALID(d2_valid), .IN_READY(d2_ready),
    .PAR_EN(d2_pe), .PAR_TYP(d2_pt), .TX_OUT(d2_tx), .BUSY(d2_busy),
    .FRAME_DONE(d2_done), .FIFO_COUNT(d2_cnt)
  );

  // Reference: list the frame's bits, then repeat each for one bit period.
  function automatic void add_frame(input logic [8:0] w, input int dw, input bit pe,
                                    input bit pt, input int sb, input int ps);
    int ones;
    bit bits[$];
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < dw; i++) begin
      bits.push_back(w[i]);
      if (w[i]) ones++;
    end
    if (pe) bits.push_back(1'(ones % 2) ^ pt);
    for (int i = 0; i < sb; i++) bits.push_back(1'b1);
    foreach (bits[i]) for (int k = 0; k < ps; k++) exp_q.push_back(bits[i]);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (d0_tx !== 1'b1)   begin errors++; $display("FAIL reset d0 tx: got %b want 1", d0_tx); end
    checks++; if (d0_busy !== 1'b0) begin errors++; $display("FAIL reset d0 busy: got %b want 0", d0_busy); end
    checks++; if (d0_done !== 1'b0) begin errors++; $display("FAIL reset d0 done: got %b want 0", d0_done); end
    checks++; if (d0_cnt !== 3'd0)  begin errors++; $display("FAIL reset d0 count: got %0d want 0", d0_cnt); end
    checks++; if (d0_ready !== 1'b1) begin errors++; $display("FAIL reset d0 ready: got %b want 1", d0_ready); end
    checks++; if (d1_tx !== 1'b1 || d1_busy !== 1'b0 || d1_cnt !== 3'd0 || d1_ready !== 1'b1)
      begin errors++; $display("FAIL reset d1: got tx=%b busy=%b cnt=%0d rdy=%b want 1 0 0 1", d1_tx, d1_busy, d1_cnt, d1_ready); end
    checks++; if (d2_tx !== 1'b1 || d2_busy !== 1'b0 || d2_cnt !== 3'd0 || d2_ready !== 1'b1)
      begin errors++; $display("FAIL reset d2: got tx=%b busy=%b cnt=%0d rdy=%b want 1 0 0 1", d2_tx, d2_busy, d2_cnt, d2_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One frame on dut0 from idle; optionally toggles parity inputs once the word is popped.
  task automatic frame_d0(input logic [7:0] w, input bit pe, input bit pt, input bit scramble,
                          input string name);
    int fl;
    exp_q.delete();
    add_frame(9'(w), 8, pe, pt, 1, 16);
    fl = exp_q.size();
    d0_data = w; d0_pe = pe; d0_pt = pt; d0_valid = 1'b1;
    checks++; if (d0_ready !== 1'b1) begin errors++; $display("FAIL %s ready: got %b want 1", name, d0_ready); end
    @(negedge clk);
    d0_valid = 1'b0;
    checks++; if (d0_tx !== 1'b1 || d0_busy !== 1'b0 || d0_cnt !== 3'd1)
      begin errors++; $display("FAIL %s latency: got tx=%b busy=%b cnt=%0d want 1 0 1", name, d0_tx, d0_busy, d0_cnt); end
    for (int c = 0; c < fl; c++) begin
      @(negedge clk);
      if (scramble) begin d0_pe = 1'($urandom_range(0, 1)); d0_pt = 1'($urandom_range(0, 1)); end
      checks++; if (d0_tx !== exp_q[c])
        begin errors++; $display("FAIL %s tx[%0d]: got %b want %b", name, c, d0_tx, exp_q[c]); end
      checks++; if (d0_done !== (c == fl - 1))
        begin errors++; $display("FAIL %s done[%0d]: got %b want %b", name, c, d0_done, (c == fl - 1)); end
      checks++; if (d0_busy !== 1'b1)
        begin errors++; $display("FAIL %s busy[%0d]: got %b want 1", name, c, d0_busy); end
    end
    @(negedge clk);
    checks++; if (d0_tx !== 1'b1 || d0_busy !== 1'b0 || d0_done !== 1'b0)
      begin errors++; $display("FAIL %s idle: got tx=%b busy=%b done=%b want 1 0 0", name, d0_tx, d0_busy, d0_done); end
  endtask

  task automatic test_parity_default();
    frame_d0(8'hAA, 1'b1, 1'b0, 1'b0, "even_aa");
  endtask

  task automatic test_parity_type();
    frame_d0(8'h04, 1'b1, 1'b1, 1'b0, "odd_04");
    frame_d0(8'h04, 1'b1, 1'b0, 1'b0, "even_04");
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 8; n++) begin
      frame_d0(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, "rand");
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
  endtask

  task automatic test_stop_bits();
    int fl;
    exp_q.delete();
    add_frame(9'h055, 8, 1'b0, 1'b0, 2, 16);
    fl = exp_q.size();
    d1_data = 8'h55; d1_pe = 1'b0; d1_pt = 1'b0; d1_valid = 1'b1;
    @(negedge clk);
    d1_valid = 1'b0;
    for (int c = 0; c < fl; c++) begin
      @(negedge clk);
      checks++; if (d1_tx !== exp_q[c])
        begin errors++; $display("FAIL stop2 tx[%0d]: got %b want %b", c, d1_tx, exp_q[c]); end
      checks++; if (d1_done !== (c == fl - 1))
        begin errors++; $display("FAIL stop2 done[%0d]: got %b want %b", c, d1_done, (c == fl - 1)); end
    end
    @(negedge clk);
    checks++; if (d1_tx !== 1'b1 || d1_busy !== 1'b0)
      begin errors++; $display("FAIL stop2 idle: got tx=%b busy=%b want 1 0", d1_tx, d1_busy); end
  endtask

  task automatic test_narrow();
    int fl;
    exp_q.delete();
    add_frame(9'h07F, 7, 1'b1, 1'b0, 1, 4);
    fl = exp_q.size();
    d2_data = 7'h7F; d2_pe = 1'b1; d2_pt = 1'b0; d2_valid = 1'b1;
    @(negedge clk);
    d2_valid = 1'b0;
    for (int c = 0; c < fl; c++) begin
      @(negedge clk);
      checks++; if (d2_tx !== exp_q[c])
        begin errors++; $display("FAIL narrow tx[%0d]: got %b want %b", c, d2_tx, exp_q[c]); end
      checks++; if (d2_done !== (c == fl - 1))
        begin errors++; $display("FAIL narrow done[%0d]: got %b want %b", c, d2_done, (c == fl - 1)); end
    end
    @(negedge clk);
    checks++; if (d2_tx !== 1'b1 || d2_busy !== 1'b0)
      begin errors++; $display("FAIL narrow idle: got tx=%b busy=%b want 1 0", d2_tx, d2_busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [6];
    int fl;
    int pulses;
    words = '{8'hAA, 8'h04, 8'h55, 8'hCC, 8'h0A, 8'h05};
    exp_q.delete();
    for (int i = 0; i < 5; i++) add_frame(9'(words[i]), 8, 1'b1, 1'b0, 1, 16);
    fl = exp_q.size() / 5;
    pulses = 0;
    d0_pe = 1'b1; d0_pt = 1'b0;
    for (int c = 0; c < 5 * fl + 6; c++) begin
      if (c < 6) begin
        d0_data = words[c]; d0_valid = 1'b1;
        checks++; if (d0_ready !== (c < 5))
          begin errors++; $display("FAIL b2b ready[%0d]: got %b want %b", c, d0_ready, (c < 5)); end
      end else begin
        d0_valid = 1'b0;
      end
      if (c == 5) begin
        checks++; if (d0_cnt !== 3'd4) begin errors++; $display("FAIL b2b full count: got %0d want 4", d0_cnt); end
      end
      if (c >= 6 && c <= 2 + fl) begin
        checks++; if (d0_ready !== (c == 2 + fl))
          begin errors++; $display("FAIL b2b hold ready[%0d]: got %b want %b", c, d0_ready, (c == 2 + fl)); end
      end
      if (c >= 2 && c < 2 + 5 * fl) begin
        checks++; if (d0_tx !== exp_q[c-2])
          begin errors++; $display("FAIL b2b tx[%0d]: got %b want %b", c, d0_tx, exp_q[c-2]); end
        checks++; if (d0_done !== ((c - 2) % fl == fl - 1))
          begin errors++; $display("FAIL b2b done[%0d]: got %b want %b", c, d0_done, ((c - 2) % fl == fl - 1)); end
      end else begin
        checks++; if (d0_tx !== 1'b1 || d0_done !== 1'b0)
          begin errors++; $display("FAIL b2b idle[%0d]: got tx=%b done=%b want 1 0", c, d0_tx, d0_done); end
      end
      if (d0_done === 1'b1) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses != 5) begin errors++; $display("FAIL b2b pulses: got %0d want 5", pulses); end
    checks++; if (d0_busy !== 1'b0 || d0_cnt !== 3'd0)
      begin errors++; $display("FAIL b2b end: got busy=%b cnt=%0d want 0 0", d0_busy, d0_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] w [3];
    localparam int RstAt = 2 + 4 * 16 + 8;  // middle of data bit 3
    for (int i = 0; i < 3; i++) w[i] = 8'($urandom);
    exp_q.delete();
    add_frame(9'(w[0]), 8, 1'b1, 1'b0, 1, 16);
    d0_pe = 1'b1; d0_pt = 1'b0;
    for (int c = 0; c < RstAt; c++) begin
      if (c < 3) begin d0_data = w[c]; d0_valid = 1'b1; end else d0_valid = 1'b0;
      if (c >= 2) begin
        checks++; if (d0_tx !== exp_q[c-2])
          begin errors++; $display("FAIL rst_mid tx[%0d]: got %b want %b", c, d0_tx, exp_q[c-2]); end
      end
      @(negedge clk);
    end
    checks++; if (d0_cnt !== 3'd2 || d0_busy !== 1'b1 || d0_tx !== w[0][3])
      begin errors++; $display("FAIL rst_mid pre: got cnt=%0d busy=%b tx=%b want 2 1 %b", d0_cnt, d0_busy, d0_tx, w[0][3]); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (d0_tx !== 1'b1 || d0_busy !== 1'b0 || d0_cnt !== 3'd0 || d0_ready !== 1'b1 || d0_done !== 1'b0)
      begin errors++; $display("FAIL rst_mid post: got tx=%b busy=%b cnt=%0d rdy=%b done=%b want 1 0 0 1 0", d0_tx, d0_busy, d0_cnt, d0_ready, d0_done); end
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      checks++; if (d0_tx !== 1'b1 || d0_busy !== 1'b0 || d0_done !== 1'b0)
        begin errors++; $display("FAIL rst_mid quiet[%0d]: got tx=%b busy=%b done=%b want 1 0 0", c, d0_tx, d0_busy, d0_done); end
    end
  endtask

  initial begin
    rst = 1'b1;
    d0_data = '0; d0_valid = 1'b0; d0_pe = 1'b0; d0_pt = 1'b0;
    d1_data = '0; d1_valid = 1'b0; d1_pe = 1'b0; d1_pt = 1'b0;
    d2_data = '0; d2_valid = 1'b0; d2_pe = 1'b0; d2_pt = 1'b0;
    test_reset();
    test_parity_default();
    test_parity_type();
    test_stop_bits();
    test_narrow();
    test_back_to_back();
    test_reset_mid_frame();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
